// File: rtl/prv_trap_sequencer.sv
// prv_trap_sequencer
// Machine-mode trap and return sequencer between the hazard unit and the CSR file.
// It picks the highest-priority event among exceptions, takeable interrupts,
// mret and wfi. It latches that event and waits for the pipeline to drain.
// It then issues one CSR commit strobe and redirects fetch.
//
// Ports:
//   CLK, RST           clock, synchronous active-high reset
//   fault_insn..fault_l exception flags from the hazard unit
//   ret, wfi           mret / wfi reached commit
//   epc, badaddr       PC of committing instruction, faulting address
//   ext_int, soft_int, timer_int  raw pending interrupts
//   mie_bits           {MEIE, MSIE, MTIE}
//   mstatus_mie        global interrupt enable
//   mtvec, mepc_r      current trap vector and saved return PC
//   pipe_clear         pipeline drained
//   insert_pc, priv_pc fetch redirect strobe and target
//   intr               latched event is an interrupt
//   trap_we, mret_we   one-cycle CSR commit strobes
//   mcause_w, mepc_w, mtval_w  CSR write data
//   busy               sequencer is not idle
module prv_trap_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0200
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        breakpoint,
  input  logic        env,
  input  logic        mal_s,
  input  logic        mal_l,
  input  logic        fault_s,
  input  logic        fault_l,
  input  logic        ret,
  input  logic        wfi,
  input  logic [31:0] epc,
  input  logic [31:0] badaddr,
  input  logic        ext_int,
  input  logic        soft_int,
  input  logic        timer_int,
  input  logic [2:0]  mie_bits,
  input  logic        mstatus_mie,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc_r,
  input  logic        pipe_clear,
  output logic        insert_pc,
  output logic [31:0] priv_pc,
  output logic        intr,
  output logic        trap_we,
  output logic        mret_we,
  output logic [31:0] mcause_w,
  output logic [31:0] mepc_w,
  output logic [31:0] mtval_w,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CLEAR,
    S_COMMIT,
    S_REDIRECT,
    S_WFI
  } state_t;

  state_t state, state_next;

  logic [2:0]  eff_int;
  logic        any_eff;
  logic        int_take;
  logic        exc_hit;
  logic [4:0]  exc_cause;
  logic [31:0] exc_tval;
  logic [4:0]  int_cause;
  logic        ev_take;
  logic        ret_take;
  logic        is_ret;
  logic [31:0] ret_pc;
  logic [31:0] vec_base;
  logic [31:0] commit_target;

  assign eff_int  = {ext_int, soft_int, timer_int} & mie_bits;
  assign any_eff  = |eff_int;
  assign int_take = mstatus_mie & any_eff;

  // Synchronous exception priority and the matching trap value
  always_comb begin
    exc_hit   = 1'b1;
    exc_cause = 5'd0;
    exc_tval  = '0;
    if (breakpoint)        exc_cause = 5'd3;
    else if (fault_insn)   exc_cause = 5'd1;
    else if (illegal_insn) exc_cause = 5'd2;
    else if (mal_insn)     exc_cause = 5'd0;
    else if (env)          exc_cause = 5'd11;
    else if (mal_s)        exc_cause = 5'd6;
    else if (mal_l)        exc_cause = 5'd4;
    else if (fault_s)      exc_cause = 5'd7;
    else if (fault_l)      exc_cause = 5'd5;
    else                   exc_hit   = 1'b0;
    case (exc_cause)
      5'd0, 5'd1, 5'd4, 5'd5, 5'd6, 5'd7: exc_tval = badaddr;
      5'd3:                               exc_tval = epc;
      default:                            exc_tval = '0;
    endcase
  end

  // Interrupt priority: external, then software, then timer
  always_comb begin
    int_cause = 5'd7;
    if (eff_int[2])      int_cause = 5'd11;
    else if (eff_int[1]) int_cause = 5'd3;
  end

  assign ev_take  = (state == S_IDLE) && (exc_hit || int_take);
  assign ret_take = (state == S_IDLE) && !exc_hit && !int_take && ret;

  // Next-state logic; event inputs only matter in IDLE
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (ev_take || ret_take)  state_next = S_WAIT_CLEAR;
        else if (wfi && !any_eff) state_next = S_WFI;
      end
      S_WAIT_CLEAR: if (pipe_clear) state_next = S_COMMIT;
      S_COMMIT:     state_next = S_REDIRECT;
      S_REDIRECT:   state_next = S_IDLE;
      S_WFI:        if (any_eff) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // Redirect target; mtvec modes 2 and 3 fall back to direct
  always_comb begin
    vec_base = {mtvec[31:2], 2'b00};
    if (is_ret)
      commit_target = ret_pc & 32'hFFFF_FFFC;
    else if (mtvec[1:0] == 2'b01 && intr)
      commit_target = vec_base + {25'd0, mcause_w[4:0], 2'b00};
    else
      commit_target = vec_base;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_IDLE;
      is_ret   <= 1'b0;
      intr     <= 1'b0;
      mcause_w <= '0;
      mepc_w   <= '0;
      mtval_w  <= '0;
      ret_pc   <= '0;
      priv_pc  <= RESET_PC;
    end else begin
      state <= state_next;
      if (ev_take) begin
        is_ret   <= 1'b0;
        intr     <= !exc_hit;
        mcause_w <= exc_hit ? {27'd0, exc_cause} : {1'b1, 26'd0, int_cause};
        mepc_w   <= epc;
        mtval_w  <= exc_hit ? exc_tval : 32'd0;
      end else if (ret_take) begin
        is_ret <= 1'b1;
        intr   <= 1'b0;
        ret_pc <= mepc_r;
      end
      if (state == S_COMMIT) priv_pc <= commit_target;
    end
  end

  assign trap_we   = (state == S_COMMIT) && !is_ret;
  assign mret_we   = (state == S_COMMIT) && is_ret;
  assign insert_pc = (state == S_REDIRECT);
  assign busy      = (state != S_IDLE);

endmodule

// File: doc/prv_trap_sequencer.md
# prv_trap_sequencer

Machine-mode trap and return sequencer between the pipeline hazard unit and the machine-mode CSR file. It prioritises simultaneous synchronous exceptions, pending interrupts and `mret`, and latches the winning event. It then waits for the pipeline to drain, issues a single CSR commit strobe, and redirects fetch to the trap vector or the saved `mepc`. It also parks the core in a WFI state until an enabled interrupt is pending.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0200: `priv_pc` value after reset.

Ports (one clock; reset is synchronous and active-high):
- `CLK`  in  1  clock; all state changes on rising edge.
- `RST`  in  1  synchronous active-high reset.
- `fault_insn, mal_insn, illegal_insn, breakpoint, env, mal_s, mal_l, fault_s, fault_l`  in  1 each  exception flags from hazard unit.
- `ret`  in  1  `mret` reached commit.
- `wfi`  in  1  `wfi` reached commit.
- `epc`  in  32  PC of the faulting or committing instruction.
- `badaddr`  in  32  faulting address.
- `ext_int, soft_int, timer_int`  in  1 each  raw pending interrupts (MEIP/MSIP/MTIP).
- `mie_bits`  in  3  enables {MEIE, MSIE, MTIE}.
- `mstatus_mie`  in  1  global interrupt enable.
- `mtvec`  in  32  [31:2] base, [1:0] mode (0 direct, 1 vectored).
- `mepc_r`  in  32  current `mepc`.
- `pipe_clear`  in  1  pipeline drained.
- `insert_pc`  out  1  one-cycle fetch redirect.
- `priv_pc`  out  32  redirect target, held between redirects.
- `intr`  out  1  latched event is an interrupt.
- `trap_we`  out  1  one-cycle strobe: write `mcause`, `mepc`, `mtval`; MIE→MPIE, MIE←0.
- `mret_we`  out  1  one-cycle strobe: MIE←MPIE, MPIE←1.
- `mcause_w`  out  32  cause, bit 31 = interrupt.
- `mepc_w`  out  32  `epc` latched at event.
- `mtval_w`  out  32  trap value.
- `busy`  out  1  high when not IDLE; hazard unit stalls fetch.

## Operation
- States: IDLE, WAIT_CLEAR, COMMIT, REDIRECT, WFI.
- Effective interrupts: `{ext_int,soft_int,timer_int} & mie_bits`. An interrupt is takeable only when `mstatus_mie` = 1.
- Event priority in IDLE, highest first:
  - breakpoint (cause 3), fault_insn (1), illegal_insn (2), mal_insn (0), env (11), mal_s (6), mal_l (4), fault_s (7), fault_l (5).
  - Then interrupts: ext (11), soft (3), timer (7).
  - Then `ret`, then `wfi`.
- Any exception or takeable interrupt in IDLE:
  - Latch cause, `intr`, `epc`→`mepc_w` and `mtval_w`.
  - `mtval_w` = `badaddr` for causes 0,1,4,5,6,7; `epc` for cause 3; 0 otherwise.
  - Go to WAIT_CLEAR.
- `ret` in IDLE: latch `mepc_r`, go to WAIT_CLEAR with a return flag set.
- `wfi` with no effective interrupt pending: go to WFI. If one is already pending, `wfi` is a no-op.
- WFI: leave to IDLE when any effective interrupt is pending, regardless of `mstatus_mie`. A takeable interrupt is then taken from IDLE on the next cycle.
- WAIT_CLEAR: hold until `pipe_clear` = 1, then COMMIT. Event inputs are ignored in every non-IDLE state.
- COMMIT: pulse `trap_we` for a trap or `mret_we` for a return. Compute target:
  - Return: latched `mepc_r` with [1:0] forced to 0.
  - Trap, direct mode or exception: `{mtvec[31:2],2'b00}`.
  - Trap, vectored mode and interrupt: `{mtvec[31:2],2'b00} + 4*cause[4:0]`, 32-bit wrap.
  - `mtvec` mode values 2 and 3 are treated as direct.
- REDIRECT: `insert_pc` = 1, `priv_pc` = target; next IDLE.

## Timing
- Reset values: state IDLE; `priv_pc` = `RESET_PC`; all other outputs 0. `RST` mid-sequence aborts with no strobe.
- Minimum latency: event at cycle N, `pipe_clear` high at N+1, `trap_we`/`mret_we` at N+2, `insert_pc` at N+3.
- `trap_we`, `mret_we` and `insert_pc` are exactly one cycle each and never coincide.
- `mcause_w`, `mepc_w` and `mtval_w` are registered and stable from N+1 until the next event.
- `busy` is high in WAIT_CLEAR, COMMIT, REDIRECT and WFI.
- `pipe_clear` high in IDLE has no effect.

## Test plan
- `illegal_insn` + `mal_l` together, `epc`=0x100, `pipe_clear` high next cycle → `mcause_w`=2, `mtval_w`=0, `mepc_w`=0x100, `trap_we` at N+2, `insert_pc` at N+3 with `priv_pc`=`mtvec` base.
- `mtvec`=0x1001, `timer_int`+`soft_int` pending, `mie_bits`=3'b011, `mstatus_mie`=1 → cause 0x8000_0003, `intr`=1, `priv_pc`=0x100C.
- `ret` with `mepc_r`=0x2002, `pipe_clear` delayed 5 cycles → `mret_we` at N+6 and `insert_pc` at N+7 with `priv_pc`=0x2000; `trap_we` stays 0.
- `wfi` with nothing pending, then `ext_int` + MEIE while `mstatus_mie`=0 → exit to IDLE, no trap. Repeat with `mstatus_mie`=1 → cause 0x8000_000B.
- `RST` asserted in COMMIT → next cycle all strobes 0, `priv_pc`=`RESET_PC`, `busy`=0.
- Second exception while in WAIT_CLEAR → ignored; only the first cause is committed.
